// File: rtl/cci_test_csr_mgr_pkg.sv
// Shared constants and types for the CCI test CSR manager.
package cci_test_csr_mgr_pkg;

  localparam int NUM_TEST_CSRS = 16;

  // Device feature header returned at index 0.
  localparam logic [63:0] DFH = 64'h1000_0100_0000_0000;

  // 64-bit CSR index map (index = DWORD address [15:1]).
  localparam logic [14:0] IDX_DFH       = 15'd0;
  localparam logic [14:0] IDX_AFU_ID_L  = 15'd1;
  localparam logic [14:0] IDX_AFU_ID_H  = 15'd2;
  localparam logic [14:0] IDX_STATUS    = 15'd5;
  localparam logic [14:0] IDX_STATS     = 15'd6;
  localparam logic [14:0] IDX_TEST_BASE = 15'd16;

  typedef logic [8:0]  t_mmio_tid;
  typedef logic [14:0] t_csr_idx;

  // One write port of a test CSR: single-cycle enable plus held data.
  typedef struct packed {
    logic        en;
    logic [63:0] data;
  } t_cpu_wr_csr;

endpackage

// File: rtl/cci_test_csr_if.sv
// Bundle between the CSR manager and the test CSR owner.
interface test_csrs;
  import cci_test_csr_mgr_pkg::*;

  logic [127:0] afu_id;
  logic [63:0]  cpu_rd_csrs [0:NUM_TEST_CSRS-1];
  t_cpu_wr_csr  cpu_wr_csrs [0:NUM_TEST_CSRS-1];

  modport csr (input afu_id, input cpu_rd_csrs, output cpu_wr_csrs);
endinterface

// File: rtl/cci_test_csr_rd_pipe.sv
// Two-stage MMIO read pipeline: stage 1 holds the decoded request, stage 2
// holds the lane-selected response. The top supplies stage-1 read data.
module cci_test_csr_rd_pipe
  import cci_test_csr_mgr_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_valid_i,
  input  logic [8:0]  rd_tid_i,
  input  logic [14:0] rd_idx_i,
  input  logic        rd_len8_i,
  input  logic        rd_odd_i,
  output logic [14:0] s1_idx_o,
  input  logic [63:0] s1_data_i,
  output logic        rsp_valid_o,
  output logic [8:0]  rsp_tid_o,
  output logic [63:0] rsp_data_o
);

  logic [2:1]  vld_pipe_q;
  t_mmio_tid   s1_tid_q, s2_tid_q;
  t_csr_idx    s1_idx_q;
  logic        s1_len8_q, s1_odd_q;
  logic [63:0] s2_data_q;
  logic [63:0] s1_lane;

  // 4-byte reads return the addressed DWORD right-justified.
  always_comb begin
    s1_lane = s1_data_i;
    if (!s1_len8_q)
      s1_lane = s1_odd_q ? {32'b0, s1_data_i[63:32]} : {32'b0, s1_data_i[31:0]};
  end

  // Advance both stages; reset kills anything in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      s1_tid_q   <= '0;
      s1_idx_q   <= '0;
      s1_len8_q  <= 1'b0;
      s1_odd_q   <= 1'b0;
      s2_tid_q   <= '0;
      s2_data_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], rd_valid_i};
      if (rd_valid_i) begin
        s1_tid_q  <= rd_tid_i;
        s1_idx_q  <= rd_idx_i;
        s1_len8_q <= rd_len8_i;
        s1_odd_q  <= rd_odd_i;
      end
      if (vld_pipe_q[1]) begin
        s2_tid_q  <= s1_tid_q;
        s2_data_q <= s1_lane;
      end
    end
  end

  assign s1_idx_o    = s1_idx_q;
  assign rsp_valid_o = vld_pipe_q[2];
  assign rsp_tid_o   = s2_tid_q;
  assign rsp_data_o  = s2_data_q;

endmodule

// File: rtl/cci_test_csr_mgr.sv
// MMIO CSR manager for the CCI test AFU: DFH/AFU ID/STATUS decode, 16 test
// CSR write strobes and a two-stage read path.
// Optional: define CCI_TEST_CSR_STATS_EN to add saturating access counters
// at index 6; otherwise index 6 reads 0.
module cci_test_csr_mgr
  import cci_test_csr_mgr_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mmio_wr_valid,
  input  logic [15:0] mmio_wr_addr,
  input  logic        mmio_wr_len8,
  input  logic [63:0] mmio_wr_data,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_rd_addr,
  input  logic        mmio_rd_len8,
  input  logic [8:0]  mmio_rd_tid,
  output logic        mmio_rsp_valid,
  output logic [8:0]  mmio_rsp_tid,
  output logic [63:0] mmio_rsp_data,
  test_csrs.csr       csrs
);

  t_csr_idx  wr_idx, rd_idx, s1_idx;
  logic      wr_is_test, wr_known, err_set, err_clr;
  logic      err_q, err_d;
  logic [NUM_TEST_CSRS-1:0] wr_hit;
  logic [63:0] stats_val, snap_d, snap_q, s1_data;

  assign wr_idx     = mmio_wr_addr[15:1];
  assign rd_idx     = mmio_rd_addr[15:1];
  assign wr_is_test = (wr_idx[14:4] == IDX_TEST_BASE[14:4]);
  assign wr_known   = (wr_idx <= IDX_STATS);

  // Write decode: strobe selection and sticky error update (set wins).
  always_comb begin
    wr_hit  = '0;
    err_set = mmio_wr_valid && ((wr_is_test && !mmio_wr_len8) || (!wr_is_test && !wr_known));
    err_clr = mmio_wr_valid && (wr_idx == IDX_STATUS) && mmio_wr_len8 && mmio_wr_data[0];
    err_d   = err_set | (err_q & ~err_clr);
    if (mmio_wr_valid && wr_is_test && mmio_wr_len8) wr_hit[wr_idx[3:0]] = 1'b1;
  end

  // Error flag and test CSR write ports; en is a one-cycle pulse, data holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
      for (int i = 0; i < NUM_TEST_CSRS; i++) begin
        csrs.cpu_wr_csrs[i].en   <= 1'b0;
        csrs.cpu_wr_csrs[i].data <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int i = 0; i < NUM_TEST_CSRS; i++) begin
        csrs.cpu_wr_csrs[i].en <= wr_hit[i];
        if (wr_hit[i]) csrs.cpu_wr_csrs[i].data <= mmio_wr_data;
      end
    end
  end

`ifdef CCI_TEST_CSR_STATS_EN
  logic [31:0] wr_cnt_q, rd_cnt_q;

  // Saturating counts of accepted writes and reads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (mmio_wr_valid && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (mmio_rd_valid && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign stats_val = {wr_cnt_q, rd_cnt_q};
`else
  assign stats_val = '0;
`endif

  // STATUS/STATS are captured with the request so a same-cycle write
  // cannot leak into the response.
  always_comb begin
    snap_d = '0;
    if (rd_idx == IDX_STATUS)     snap_d = {63'b0, err_q};
    else if (rd_idx == IDX_STATS) snap_d = stats_val;
  end

  // Snapshot register travels alongside pipeline stage 1.
  always_ff @(posedge clk) begin
    if (!reset_n)           snap_q <= '0;
    else if (mmio_rd_valid) snap_q <= snap_d;
  end

  // Stage-1 read mux; live inputs are sampled here.
  always_comb begin
    s1_data = '0;
    case (s1_idx)
      IDX_DFH:               s1_data = DFH;
      IDX_AFU_ID_L:          s1_data = csrs.afu_id[63:0];
      IDX_AFU_ID_H:          s1_data = csrs.afu_id[127:64];
      IDX_STATUS, IDX_STATS: s1_data = snap_q;
      default:
        if (s1_idx[14:4] == IDX_TEST_BASE[14:4]) s1_data = csrs.cpu_rd_csrs[s1_idx[3:0]];
    endcase
  end

  cci_test_csr_rd_pipe u_rd_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_valid_i  (mmio_rd_valid),
    .rd_tid_i    (mmio_rd_tid),
    .rd_idx_i    (rd_idx),
    .rd_len8_i   (mmio_rd_len8),
    .rd_odd_i    (mmio_rd_addr[0]),
    .s1_idx_o    (s1_idx),
    .s1_data_i   (s1_data),
    .rsp_valid_o (mmio_rsp_valid),
    .rsp_tid_o   (mmio_rsp_tid),
    .rsp_data_o  (mmio_rsp_data)
  );

endmodule

// File: doc/cci_test_csr_mgr.md
CCI_TEST_CSR_MGR -- requirements
Module: cci_test_csr_mgr

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all logic is on its rising edge.
REQ-002 SHALL have reset_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have mmio_wr_valid, input, 1, host MMIO write strobe; one write per cycle.
REQ-004 SHALL have mmio_wr_addr, input, 16, DWORD (4-byte) address; 64-bit CSR index = addr[15:1].
REQ-005 SHALL have mmio_wr_len8, input, 1, 1 = 8-byte access, 0 = 4-byte access.
REQ-006 SHALL have mmio_wr_data, input, 64, write data.
REQ-007 SHALL have mmio_rd_valid, input, 1, host MMIO read request strobe; one request per cycle.
REQ-008 SHALL have mmio_rd_addr, input, 16, DWORD address of the read.
REQ-009 SHALL have mmio_rd_len8, input, 1, read length, same encoding as mmio_wr_len8.
REQ-010 SHALL have mmio_rd_tid, input, 9, read transaction ID.
REQ-011 SHALL have mmio_rsp_valid, output, 1, read response strobe; there is no backpressure.
REQ-012 SHALL have mmio_rsp_tid, output, 9, echoed transaction ID.
REQ-013 SHALL have mmio_rsp_data, output, 64, read response data.
REQ-014 SHALL have csrs, modport test_csrs.csr, which supplies afu_id and cpu_rd_csrs[0:15] and receives cpu_wr_csrs[0:15].

Function
REQ-015 SHALL decode the 64-bit index map as follows:
- 0: DFH, constant 0x1000_0100_0000_0000.
- 1: afu_id[63:0].
- 2: afu_id[127:64].
- 3, 4: reserved; read as 0.
- 5: STATUS; bit0 is sticky err; all other bits read 0.
- 6: STATS (see Configuration).
- 16..31: test CSR i = index-16.
- All other indexes are unmapped.
REQ-016 SHALL, for an 8-byte write to index 16..31 at cycle N, drive cpu_wr_csrs[i].en=1 and .data=mmio_wr_data for exactly cycle N+1; all other en bits are 0.
REQ-017 SHALL drive every cpu_wr_csrs[].en to 0 in any cycle without a qualifying write; .data holds its last written value.
REQ-018 SHALL drop a 4-byte write to index 16..31 (no en pulse) and set err.
REQ-019 SHALL clear err on an 8-byte write to index 5 with data bit0=1; writes to indexes 0..4 and 6 are ignored without error.
REQ-020 SHALL set err on a write to an unmapped index; if a set and a clear of err occur in the same cycle, set wins.
REQ-021 SHALL answer a read accepted at cycle N with mmio_rsp_valid=1 and mmio_rsp_tid=tid at cycle N+2, using a two-stage pipeline (registered decode, registered mux).
REQ-022 SHALL sustain a read every cycle with responses returned in request order.
REQ-023 SHALL return 0 for reads of unmapped indexes and shall not set err on them.
REQ-024 SHALL return the selected 64-bit value for 8-byte reads; a 4-byte read at an odd DWORD address returns the upper 32 bits in [31:0] with [63:32]=0, and at an even address the lower 32 bits with [63:32]=0.
REQ-025 SHALL have a read and a write in the same cycle both take effect; the read returns the pre-write state of STATUS/STATS.
REQ-026 SHALL sample cpu_rd_csrs in the cycle the read enters stage 1 (N+1).

Reset
REQ-027 SHALL, while reset_n=0, drive mmio_rsp_valid=0, mmio_rsp_tid=0, mmio_rsp_data=0, all cpu_wr_csrs en=0 and data=0, err=0, and STATS=0.
REQ-028 SHALL discard reads in flight when reset is asserted mid-operation; no response is ever issued for them.
REQ-029 SHALL ignore requests presented while reset_n=0.

Configuration
REQ-030 SHALL, with CCI_TEST_CSR_STATS_EN defined, implement index 6 as STATS, where [63:32] counts accepted writes and [31:0] counts accepted reads; both counters saturate at 0xFFFF_FFFF.
REQ-031 SHALL, without CCI_TEST_CSR_STATS_EN, read index 6 as 0 and contain no counter logic.

Structure
REQ-032 SHALL place the following in package cci_test_csr_mgr_pkg:
- the DFH constant;
- index constants (IDX_DFH, IDX_AFU_ID_L, IDX_AFU_ID_H, IDX_STATUS, IDX_STATS, IDX_TEST_BASE);
- the t_mmio_tid typedef.
REQ-033 SHALL place the read pipeline in sub-module cci_test_csr_rd_pipe, which carries valid, tid, index and length through two stages.

Verification
REQ-034 SHALL cover: an 8-byte write of 0xDEAD_BEEF_0123_4567 to DWORD 0x24 (index 18) -> cpu_wr_csrs[2].en=1 with that data one cycle later only.
REQ-035 SHALL cover: back-to-back reads of indexes 0, 1, 2 with tids 5, 6, 7 -> responses in cycles N+2..N+4 carrying 0x1000_0100_0000_0000, afu_id[63:0], afu_id[127:64] with matching tids.
REQ-036 SHALL cover: a 4-byte write to DWORD 0x20 -> no en pulse and STATUS reads 0x1; then an 8-byte write of 0x1 to index 5 -> STATUS reads 0x0.
REQ-037 SHALL cover: a 4-byte read at odd DWORD 0x21 with cpu_rd_csrs[0]=0xAAAA_BBBB_CCCC_DDDD -> rsp_data=0x0000_0000_AAAA_BBBB.
REQ-038 SHALL cover: reset_n deasserted one cycle after a read request -> no mmio_rsp_valid within 4 cycles.
REQ-039 SHALL cover: with STATS_EN, 3 writes and 2 reads -> a STATS read returns 0x0000_0003_0000_0002.
